// File: rtl/sprite_pixel_server_pkg.sv
// Shared constants and types for the sprite pixel server and its animation controller.
package sprite_pixel_server_pkg;

  localparam logic [11:0] SPR_TRANSPARENT = 12'hFFF;
  localparam int          SPR_COORD_BITS  = 7;
  localparam int          RGB_BITS        = 12;

  typedef enum logic [1:0] {
    ANIM_STOPPED = 2'd0,
    ANIM_PLAYING = 2'd1,
    ANIM_DONE    = 2'd2
  } anim_state_t;

  // Bit width needed to hold 0..n-1, never less than one bit.
  function automatic int width_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Animation sequencer: vsync edge detect, tick counter, play/stop/done FSM and the
// displayed frame register, which only ever changes on a vsync rising edge.
module sprite_anim_ctrl
  import sprite_pixel_server_pkg::*;
#(
  parameter  int FRAMES = 4,
  parameter  int TICKS  = 8,
  localparam int FW     = width_min1(FRAMES),
  localparam int TW     = width_min1(TICKS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          vsync,
  input  logic          anim_start,
  input  logic          anim_stop,
  input  logic          anim_loop,
  output logic [FW-1:0] frame_idx,
  output logic          anim_done
);

  anim_state_t   state;
  logic [TW-1:0] tick_cnt;
  logic [FW-1:0] pending_frame;
  logic          vsync_q;
  logic          vs_rise;

  assign vs_rise = vsync & ~vsync_q;

  // Pulses are resolved first; on a vs_rise the frame register always takes the
  // pending frame as it stands after the pulse, so a restart never shows mid-scan.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= ANIM_STOPPED;
      tick_cnt      <= '0;
      pending_frame <= '0;
      vsync_q       <= 1'b0;
      frame_idx     <= '0;
      anim_done     <= 1'b0;
    end else begin
      vsync_q <= vsync;
      if (anim_start) begin
        state         <= ANIM_PLAYING;
        tick_cnt      <= '0;
        pending_frame <= '0;
        anim_done     <= 1'b0;
        if (vs_rise) frame_idx <= '0;
      end else if (anim_stop) begin
        state     <= ANIM_STOPPED;
        anim_done <= 1'b0;
        if (vs_rise) frame_idx <= pending_frame;
      end else if (vs_rise) begin
        frame_idx <= pending_frame;
        if (state == ANIM_PLAYING) begin
          if (tick_cnt == TW'(TICKS - 1)) begin
            tick_cnt <= '0;
            if (pending_frame == FW'(FRAMES - 1)) begin
              if (anim_loop) begin
                pending_frame <= '0;
              end else begin
                state     <= ANIM_DONE;
                anim_done <= 1'b1;
              end
            end else begin
              pending_frame <= pending_frame + FW'(1);
            end
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
      end
    end
  end

endmodule

// File: rtl/sprite_pixel_server.sv
// Sprite pixel responder: multi-frame sprite RAM with a runtime write port, 1-clk
// registered read of {rel_y, rel_x} in the currently displayed animation frame.
module sprite_pixel_server
  import sprite_pixel_server_pkg::*;
#(
  parameter  int SPR_W  = 48,
  parameter  int SPR_H  = 64,
  parameter  int FRAMES = 4,
  parameter  int TICKS  = 8,
  localparam int FW     = width_min1(FRAMES),
  localparam int DEPTH  = FRAMES * SPR_W * SPR_H,
  localparam int AW     = width_min1(DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [2*SPR_COORD_BITS-1:0] pixel_addr,
  output logic [RGB_BITS-1:0]         rgb_pixel,
  input  logic                        vsync,
  input  logic                        anim_start,
  input  logic                        anim_stop,
  input  logic                        anim_loop,
  output logic                        anim_done,
  output logic [FW-1:0]               frame_idx,
  input  logic                        wr_en,
  input  logic [AW-1:0]               wr_addr,
  input  logic [RGB_BITS-1:0]         wr_data
);

  localparam int FRAME_PIX = SPR_W * SPR_H;

  logic [RGB_BITS-1:0]       mem [DEPTH];
  logic [SPR_COORD_BITS-1:0] rel_x;
  logic [SPR_COORD_BITS-1:0] rel_y;
  logic                      in_bounds;
  logic [AW-1:0]             rd_addr;
  logic                      wr_ok;

  assign rel_x = pixel_addr[SPR_COORD_BITS-1:0];
  assign rel_y = pixel_addr[2*SPR_COORD_BITS-1:SPR_COORD_BITS];

  // Compare one bit wider so a full 128-pixel dimension does not wrap to zero.
  assign in_bounds = ({1'b0, rel_x} < (SPR_COORD_BITS + 1)'(SPR_W)) &&
                     ({1'b0, rel_y} < (SPR_COORD_BITS + 1)'(SPR_H));

  assign rd_addr = AW'(frame_idx) * AW'(FRAME_PIX) + AW'(rel_y) * AW'(SPR_W) + AW'(rel_x);

  assign wr_ok = wr_en && ({1'b0, wr_addr} < (AW + 1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_addr] <= wr_data;
  end

  // Read-first: the nonblocking write above lands after this read samples the array.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_pixel <= SPR_TRANSPARENT;
    end else if (in_bounds) begin
      rgb_pixel <= mem[rd_addr];
    end else begin
      rgb_pixel <= SPR_TRANSPARENT;
    end
  end

  sprite_anim_ctrl #(
    .FRAMES (FRAMES),
    .TICKS  (TICKS)
  ) u_anim (
    .clk        (clk),
    .rst_n      (rst_n),
    .vsync      (vsync),
    .anim_start (anim_start),
    .anim_stop  (anim_stop),
    .anim_loop  (anim_loop),
    .frame_idx  (frame_idx),
    .anim_done  (anim_done)
  );

endmodule

// File: tb/tb_sprite_pixel_server.sv
// Self-checking bench for sprite_pixel_server: table-driven reads, hand-written
// animation sequences and a randomized run against a vsync-counting reference model.
module tb_sprite_pixel_server;

  localparam int SPR_W  = 48;
  localparam int SPR_H  = 64;
  localparam int FRAMES = 4;
  localparam int TICKS  = 2;
  localparam int DEPTH  = FRAMES * SPR_W * SPR_H;
  localparam int AW     = 14;
  localparam int FW     = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [13:0]   pixel_addr;
  logic [11:0]   rgb_pixel;
  logic          vsync, anim_start, anim_stop, anim_loop, anim_done;
  logic [FW-1:0] frame_idx;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [11:0]   wr_data;

  sprite_pixel_server #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .FRAMES(FRAMES), .TICKS(TICKS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pixel_addr(pixel_addr), .rgb_pixel(rgb_pixel),
    .vsync(vsync), .anim_start(anim_start), .anim_stop(anim_stop),
    .anim_loop(anim_loop), .anim_done(anim_done), .frame_idx(frame_idx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  logic [11:0] ref_mem [DEPTH];
  int  n_cmp  = 0;
  int  n_fail = 0;
  int  k_play;
  bit  playing, done_m, loop_m;
  int  exp_frame;

  function automatic logic [11:0] model_pix(input int frame, input logic [13:0] a);
    int x, y;
    x = int'(a[6:0]);
    y = int'(a[13:7]);
    if (x >= SPR_W || y >= SPR_H) return 12'hFFF;
    return ref_mem[frame * SPR_W * SPR_H + y * SPR_W + x];
  endfunction

  // Frame shown by the vsync that arrives after k playing vsyncs since the last start.
  function automatic int model_frame(input int k);
    int step;
    step = k / TICKS;
    if (loop_m) return step % FRAMES;
    return (step > FRAMES - 1) ? FRAMES - 1 : step;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic write_word(input int a, input logic [11:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
    if (a < DEPTH) ref_mem[a] = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic do_vsync();
    @(negedge clk); vsync = 1'b1;
    @(negedge clk); vsync = 1'b0;
  endtask

  task automatic pulse(input bit start, input bit stop);
    @(negedge clk); anim_start = start; anim_stop = stop;
    @(negedge clk); anim_start = 1'b0; anim_stop = 1'b0;
  endtask

  task automatic model_vsync();
    exp_frame = model_frame(k_play);
    if (playing && !done_m) begin
      k_play++;
      if (!loop_m && k_play >= TICKS * FRAMES) done_m = 1'b1;
    end
  endtask

  task automatic read_check(input string name, input logic [13:0] a);
    @(negedge clk); pixel_addr = a;
    @(negedge clk); check(name, 16'(rgb_pixel), 16'(model_pix(exp_frame, a)));
  endtask

  typedef struct {
    logic [13:0] addr;
    logic [11:0] exp_rgb;
  } rd_vec_t;

  rd_vec_t vec[8];
  int loop_seq[10];
  logic [11:0] old_v, new_v;

  initial begin
    rst_n = 1'b0; pixel_addr = '0; vsync = 1'b0; anim_start = 1'b0; anim_stop = 1'b0;
    anim_loop = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    loop_m = 1'b1; k_play = 0; playing = 1'b0; done_m = 1'b0; exp_frame = 0;

    // ---- reset state ----
    repeat (3) @(negedge clk);
    check("reset_rgb", 16'(rgb_pixel), 16'hFFF);
    check("reset_frame", 16'(frame_idx), 16'd0);
    check("reset_done", 16'(anim_done), 16'd0);
    rst_n = 1'b1;

    // ---- load RAM through the write port ----
    for (int a = 0; a < DEPTH; a++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = 12'($urandom_range(0, 4094));
      ref_mem[a] = wr_data;
    end
    @(negedge clk); wr_en = 1'b0;
    write_word(0, 12'h0F0);
    write_word(47, 12'h123);
    write_word(48, 12'h456);
    write_word(3071, 12'hABC);

    // ---- table-driven back-to-back reads on frame 0 ----
    vec[0] = '{{7'd0, 7'd0}, 12'h0F0};
    vec[1] = '{{7'd0, 7'd47}, 12'h123};
    vec[2] = '{{7'd1, 7'd0}, 12'h456};
    vec[3] = '{{7'd63, 7'd47}, 12'hABC};
    vec[4] = '{{7'd0, 7'd48}, 12'hFFF};
    vec[5] = '{{7'd64, 7'd0}, 12'hFFF};
    vec[6] = '{{7'd127, 7'd127}, 12'hFFF};
    vec[7] = '{{7'd63, 7'd48}, 12'hFFF};
    @(negedge clk); pixel_addr = vec[0].addr;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check($sformatf("table_rd%0d", i), 16'(rgb_pixel), 16'(vec[i].exp_rgb));
      if (i < 7) pixel_addr = vec[i + 1].addr;
    end

    // ---- random back-to-back reads on frame 0 ----
    begin
      logic [13:0] prev_a;
      @(negedge clk);
      prev_a = {7'($urandom_range(0, 70)), 7'($urandom_range(0, 55))};
      pixel_addr = prev_a;
      for (int i = 0; i < 150; i++) begin
        @(negedge clk);
        check("rand_rd", 16'(rgb_pixel), 16'(model_pix(0, prev_a)));
        prev_a = {7'($urandom_range(0, 70)), 7'($urandom_range(0, 55))};
        pixel_addr = prev_a;
      end
    end

    // ---- read-first collision and out-of-range write ----
    old_v = ref_mem[5];
    new_v = ~old_v;
    @(negedge clk);
    pixel_addr = 14'd5; wr_en = 1'b1; wr_addr = 14'd5; wr_data = new_v;
    @(negedge clk);
    wr_en = 1'b0;
    check("rd_first_old", 16'(rgb_pixel), 16'(old_v));
    ref_mem[5] = new_v;
    @(negedge clk);
    check("rd_first_new", 16'(rgb_pixel), 16'(new_v));
    write_word(DEPTH + 5, 12'h000);
    read_check("oob_write_ignored", 14'd5);

    // ---- looping animation: TICKS=2, 10 vsyncs ----
    loop_seq = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    anim_loop = 1'b1;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      do_vsync();
      check($sformatf("loop_v%0d", i + 1), 16'(frame_idx), 16'(loop_seq[i]));
      check("loop_done", 16'(anim_done), 16'd0);
    end

    // ---- one-shot: parks on the last frame with anim_done ----
    anim_loop = 1'b0;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 12; i++) begin
      do_vsync();
      check($sformatf("oneshot_v%0d", i + 1), 16'(frame_idx), 16'((i < 8) ? i / 2 : 3));
      check($sformatf("oneshot_done%0d", i + 1), 16'(anim_done), 16'((i >= 7) ? 1 : 0));
    end

    // ---- tear-free restart mid-line on frame 2 ----
    anim_loop = 1'b1; loop_m = 1'b1;
    pulse(1'b1, 1'b0);
    repeat (5) do_vsync();
    check("tear_pre", 16'(frame_idx), 16'd2);
    exp_frame = 2;
    pulse(1'b1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      read_check("tear_rgb_f2", {7'($urandom_range(0, 63)), 7'($urandom_range(0, 47))});
      check("tear_hold", 16'(frame_idx), 16'd2);
    end
    do_vsync();
    check("tear_after_vs", 16'(frame_idx), 16'd0);
    k_play = 1; playing = 1'b1; done_m = 1'b0; exp_frame = 0;

    // ---- start and stop together: start wins ----
    pulse(1'b1, 1'b1);
    k_play = 0; playing = 1'b1; done_m = 1'b0;
    for (int i = 0; i < 3; i++) begin
      do_vsync(); model_vsync();
    end
    check("start_over_stop", 16'(frame_idx), 16'(exp_frame));

    // ---- start on the same clk as a vsync rise: frame 0 on that edge ----
    @(negedge clk); vsync = 1'b1; anim_start = 1'b1;
    @(negedge clk); vsync = 1'b0; anim_start = 1'b0;
    check("start_with_vs", 16'(frame_idx), 16'd0);
    pulse(1'b1, 1'b0);
    k_play = 0; playing = 1'b1; done_m = 1'b0; exp_frame = 0;

    // ---- randomized animation session against the model ----
    for (int it = 0; it < 120; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r <= 5) begin
        do_vsync(); model_vsync();
        check("rand_frame", 16'(frame_idx), 16'(exp_frame));
        check("rand_done", 16'(anim_done), 16'(done_m));
      end else if (r == 6) begin
        loop_m = 1'($urandom_range(0, 1));
        anim_loop = loop_m;
        pulse(1'b1, 1'b0);
        k_play = 0; playing = 1'b1; done_m = 1'b0;
        check("rand_start_done", 16'(anim_done), 16'd0);
      end else if (r == 7) begin
        pulse(1'b0, 1'b1);
        playing = 1'b0; done_m = 1'b0;
        check("rand_stop_done", 16'(anim_done), 16'd0);
      end else begin
        read_check("rand_anim_rd", {7'($urandom_range(0, 66)), 7'($urandom_range(0, 50))});
      end
    end

    // ---- asynchronous reset mid-line ----
    anim_loop = 1'b1; loop_m = 1'b1;
    pulse(1'b1, 1'b0);
    k_play = 0; playing = 1'b1; done_m = 1'b0;
    repeat (3) begin
      do_vsync(); model_vsync();
    end
    check("prerst_frame", 16'(frame_idx), 16'd1);
    read_check("prerst_rgb", 14'd0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_rgb", 16'(rgb_pixel), 16'hFFF);
    check("async_rst_frame", 16'(frame_idx), 16'd0);
    check("async_rst_done", 16'(anim_done), 16'd0);
    @(negedge clk); rst_n = 1'b1;
    exp_frame = 0;
    read_check("ram_kept_after_rst", 14'd0);
    check("ram_kept_value", 16'(ref_mem[0]), 16'h0F0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
